// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluation controller.
// Optional majority voting is enabled by defining PUF_MAJORITY_VOTE_EN.
package puf_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int NUM_BITS_DEF = 8;
    localparam int SEL_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } puf_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side start/busy/valid handshake and response bus of the PUF evaluation controller.
// Optional majority voting is enabled by defining PUF_MAJORITY_VOTE_EN.
interface puf_eval_ctrl_if #(
    parameter int NUM_BITS = 8
);
    logic                start;
    logic [4:0]          challenge;
    logic                busy;
    logic                valid;
    logic [NUM_BITS-1:0] response;
    logic                sat;

    modport master (
        output start, challenge,
        input  busy, valid, response, sat
    );

    modport slave (
        input  start, challenge,
        output busy, valid, response, sat
    );
endinterface

// File: rtl/puf_bit_cmp.sv
// Per-measurement count comparison, saturation detect and response-bit assembly.
// With PUF_MAJORITY_VOTE_EN defined, each bit is the majority of three comparisons.
module puf_bit_cmp
    import puf_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_BITS = NUM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                sample,
`ifdef PUF_MAJORITY_VOTE_EN
    input  logic                last_pass,
`endif
    input  logic [2:0]          bit_idx,
    input  logic [CNT_W-1:0]    count_a,
    input  logic [CNT_W-1:0]    count_b,
    output logic [NUM_BITS-1:0] response,
    output logic                sat
);

    logic gt;
    logic sat_hit;
    logic bit_val;
    logic bit_wr;

    // Counts are only looked at on the SAMPLE cycle, after the settle window.
    assign gt      = (count_a > count_b);
    assign sat_hit = (&count_a) | (&count_b);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] votes;

    // votes holds at most 2 before the last pass, so the sum fits in 2 bits
    assign bit_val = ((votes + {1'b0, gt}) >= 2'd2);
    assign bit_wr  = sample & last_pass;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            votes <= '0;
        end else if (sample) begin
            votes <= last_pass ? 2'd0 : votes + {1'b0, gt};
        end
    end
`else
    assign bit_val = gt;
    assign bit_wr  = sample;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            response <= '0;
            sat      <= 1'b0;
        end else begin
            if (sample) begin
                sat <= sat | sat_hit;
            end
            if (bit_wr) begin
                for (int i = 0; i < NUM_BITS; i++) begin
                    if (bit_idx == 3'(i)) begin
                        response[i] <= bit_val;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer for the ring-oscillator PUF banks: clear, run, settle, sample per response bit.
// Define PUF_MAJORITY_VOTE_EN to measure every bit three times and keep the majority.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int NUM_BITS      = NUM_BITS_DEF,
    parameter int WINDOW_CYCLES = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int CLR_CYCLES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    puf_eval_ctrl_if.slave   host,
    input  logic [CNT_W-1:0] count_a,
    input  logic [CNT_W-1:0] count_b,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic [SEL_W-1:0] sel
);

    localparam int TMAX = max3(WINDOW_CYCLES, SETTLE_CYCLES, CLR_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] CLR_LD = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] WIN_LD = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(NUM_BITS - 1);

    puf_state_e       state;
    logic [TW-1:0]    cnt;
    logic [SEL_W-1:0] base;
    logic [2:0]       bit_idx;
    logic             busy_q;
    logic             valid_q;
    logic             accept;
    logic             sample;
    logic             last_pass;
    logic             unused_chal;

    assign accept      = (state == ST_IDLE) && host.start;
    assign sample      = (state == ST_SAMPLE);
    assign unused_chal = ^host.challenge[4:3];

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] pass;
    assign last_pass = (pass == 2'd2);
`else
    assign last_pass = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            base    <= '0;
            bit_idx <= '0;
            sel     <= '0;
            osc_en  <= 1'b0;
            cnt_clr <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.start) begin
                        base    <= host.challenge[2:0];
                        sel     <= host.challenge[2:0];
                        bit_idx <= '0;
                        busy_q  <= 1'b1;
                        cnt_clr <= 1'b1;
                        cnt     <= CLR_LD;
                        state   <= ST_CLEAR;
`ifdef PUF_MAJORITY_VOTE_EN
                        pass    <= '0;
`endif
                    end
                end
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        cnt_clr <= 1'b0;
                        osc_en  <= 1'b1;
                        cnt     <= WIN_LD;
                        state   <= ST_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        osc_en <= 1'b0;
                        cnt    <= SET_LD;
                        state  <= ST_SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                    pass <= last_pass ? 2'd0 : pass + 2'd1;
`endif
                    // Repeat passes keep the same sel; only the final pass advances the bit.
                    if (last_pass && (bit_idx == LAST_BIT)) begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        if (last_pass) begin
                            bit_idx <= bit_idx + 3'd1;
                            sel     <= base + bit_idx + 3'd1;
                        end
                        cnt_clr <= 1'b1;
                        cnt     <= CLR_LD;
                        state   <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign host.busy  = busy_q;
    assign host.valid = valid_q;

    puf_bit_cmp #(
        .CNT_W    (CNT_W),
        .NUM_BITS (NUM_BITS)
    ) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .sample    (sample),
`ifdef PUF_MAJORITY_VOTE_EN
        .last_pass (last_pass),
`endif
        .bit_idx   (bit_idx),
        .count_a   (count_a),
        .count_b   (count_b),
        .response  (host.response),
        .sat       (host.sat)
    );

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Upstream sequencer and downstream response collector for the ring-oscillator PUF banks.
- Drives the bank enable, counter clear and oscillator select.
- Times a fixed measurement window, then compares the two bank counts.
- Assembles NUM_BITS comparison bits into one response word, with a start/busy/valid handshake.
- Replaces the free-running ena/rst_n drive of the oscillator banks with a clocked, repeatable evaluation.

Parameters:
- CNT_W, 8, width of each bank count.
- NUM_BITS, 8, number of response bits per evaluation; legal range 1..8 (bit_idx is 3 bits).
- WINDOW_CYCLES, 64, clk cycles osc_en is held high per measurement; minimum 1.
- SETTLE_CYCLES, 4, clk cycles after osc_en falls before counts are sampled; minimum 2, covers ripple-counter settling.
- CLR_CYCLES, 2, clk cycles cnt_clr is held high per measurement; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin evaluation; sampled only in IDLE
- challenge  in  5  [2:0] base oscillator index; [4:3] reserved, ignored
- count_a  in  CNT_W  bank A count; asynchronous to clk, stable only when osc_en is low
- count_b  in  CNT_W  bank B count; same rules as count_a
- osc_en  out  1  oscillator enable to both banks
- cnt_clr  out  1  active-high counter clear to both banks
- sel  out  3  oscillator select to both banks' muxes
- busy  out  1  evaluation in progress
- valid  out  1  one-cycle pulse when response is complete
- response  out  NUM_BITS  PUF response, held until the next start is accepted
- sat  out  1  sticky: some sampled count equalled all-ones during this evaluation

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0, including response, sat, osc_en and cnt_clr. Reset during any state aborts immediately; no partial response is published.
- States and transitions:
  - IDLE: start=1 -> latch challenge[2:0] as base, bit_idx=0, response=0, sat=0, busy=1; go to CLEAR.
  - CLEAR: cnt_clr=1, osc_en=0 for CLR_CYCLES; go to RUN.
  - RUN: osc_en=1, cnt_clr=0 for WINDOW_CYCLES; go to SETTLE.
  - SETTLE: osc_en=0 for SETTLE_CYCLES; go to SAMPLE.
  - SAMPLE (1 cycle): capture count_a and count_b into registers.
    - Bit = (count_a > count_b), unsigned; a tie gives 0.
    - response[bit_idx] = bit.
    - sat |= (count_a == all-ones) | (count_b == all-ones).
    - If bit_idx == NUM_BITS-1, go to DONE; else bit_idx++ and go to CLEAR.
  - DONE (1 cycle): valid=1, busy=0; go to IDLE.
- sel = (base + bit_idx) mod 8, registered; stable from CLEAR through SAMPLE of each bit.
- count_a and count_b are read only in SAMPLE. No synchronizer; the settle time guarantees the counts are quiescent.
- start while busy is ignored. start held high in IDLE starts a new evaluation on the cycle after DONE.
- Timing:
  - Per-bit cost T = CLR_CYCLES + WINDOW_CYCLES + SETTLE_CYCLES + 1.
  - valid rises NUM_BITS*T + 1 edges after the start-accept edge; default 8*71+1 = 569.
  - busy is high for exactly NUM_BITS*T cycles.
- Internal cycle counter is wide enough for max(WINDOW_CYCLES, SETTLE_CYCLES, CLR_CYCLES); it reloads on every state entry.

Optional Feature:
- Macro PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each response bit is measured 3 times (three full CLEAR/RUN/SETTLE/SAMPLE passes with the same sel).
  - The bit is the majority of the 3 comparisons; sat accumulates across all passes.
  - A 2-bit pass counter is added; T triples; default latency becomes 3*8*71+1 = 1705.
- Undefined: single pass per bit as above; no pass counter is present.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE);
  - CNT_W and NUM_BITS defaults;
  - the mux select width constant (3).
- One natural sub-module, puf_bit_cmp: registered count capture, the greater-than compare, the saturation detect and, under PUF_MAJORITY_VOTE_EN, the 3-sample majority accumulator.
- The FSM and timers stay in puf_eval_ctrl.

Test Plan:
- count_a=0x40, count_b=0x20 constant; start with challenge=5'b00000 -> valid at edge 569, response=0xFF, sat=0; sel steps 0..7.
- Bank model returns a>b only when sel is odd; challenge[2:0]=3 -> sel sequence 3,4,5,6,7,0,1,2, response=0x55.
- count_a=count_b=0x33 -> response=0x00; count_a=0xFF on the bit 5 pass only -> sat=1 at valid.
- Pulse start every cycle while busy -> exactly one valid; a new start is accepted only after DONE.
- Drop rst_n in RUN of bit 3 -> next edge: osc_en=0, busy=0, response=0, no valid; a fresh start completes normally.
- PUF_MAJORITY_VOTE_EN: comparisons per bit a>b, a<b, a>b -> bit=1; a<b, a<b, a>b -> bit=0; valid at edge 1705.
